mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Shares the single data-memory port (memory_controller + BRAM) between the
//  instruction-fetch unit and the load/store unit of the RISC-V core.
//  Round-robin arbitration, one transaction at a time. Places store data in the
//  correct byte lanes and aligns/extends load data. Misaligned data accesses are
//  rejected without touching memory.
// PARAMETERS
//  ADDR_W  10  byte-address width of both requesters and the memory side
//  RD_LAT  1   BRAM read latency in cycles after mem_read (legal 1..4)
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  if_req        in   1       fetch request (word read)
//  if_addr       in   ADDR_W  fetch byte address
//  if_gnt        out  1       fetch accepted (1-cycle pulse)
//  if_rvalid     out  1       fetch data valid (1-cycle pulse)
//  if_rdata      out  32      fetched instruction word
//  d_req         in   1       load/store request
//  d_we          in   1       1 = store, 0 = load
//  d_size        in   2       00 byte, 01 half, 10 word (11 treated as word)
//  d_unsigned    in   1       load zero-extends when 1 (LBU/LHU)
//  d_addr        in   ADDR_W  data byte address
//  d_wdata       in   32      store data, right-justified
//  d_gnt         out  1       data request accepted (1-cycle pulse)
//  d_misaligned  out  1       accepted request was misaligned, not performed (pulse with d_gnt)
//  d_rvalid      out  1       load data valid (1-cycle pulse)
//  d_rdata       out  32      aligned, extended load data
//  mem_read      out  1       read strobe to memory_controller
//  mem_write     out  1       write strobe to memory_controller
//  mem_size      out  2       byte_enable code to memory_controller (00/01/10)
//  mem_addr      out  ADDR_W  byte address to memory_controller
//  mem_wdata     out  32      lane-shifted store data
//  mem_rdata     in   32      raw word from BRAM, valid RD_LAT cycles after mem_read
// BEHAVIOUR
//  - All outputs registered. Async reset: every output 0, state IDLE, rr pointer = "fetch last".
//  - States: IDLE -> ISSUE -> (read: WAIT) -> IDLE; write or misaligned: ISSUE -> IDLE.
//  - Requests sampled only in IDLE; req in ISSUE/WAIT ignored. Payload captured at the
//    sampling edge; requester holds req+payload until it sees gnt, then may drop/change.
//  - Arbitration (IDLE, both req): grant the one NOT granted last; single req wins alone.
//    rr pointer updates on every grant. After reset data wins a tie.
//  - ISSUE (1 cycle): gnt pulse to winner; mem_read or mem_write = 1 for this cycle only,
//    with mem_addr, mem_size, mem_wdata stable. Fetch: mem_size = 10.
//  - Store lanes: mem_wdata = d_wdata << 8*addr[1:0]; mem_size = d_size.
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> ISSUE pulses d_gnt and
//    d_misaligned, mem_read/mem_write stay 0, no rvalid, return to IDLE.
//  - WAIT: counter loads RD_LAT-1 on ISSUE exit; at count 0 capture mem_rdata, go IDLE;
//    rvalid pulses the following cycle (first IDLE cycle, may overlap next sampling).
//  - Load latency: req cycle 0, gnt/mem_read cycle 1, rvalid cycle 2+RD_LAT.
//    Store: req cycle 0, gnt/mem_write cycle 1, next sample cycle 2.
//  - Load extraction: w = mem_rdata >> 8*addr[1:0]; byte -> w[7:0], half -> w[15:0],
//    sign-extend unless d_unsigned; word -> w. Fetch data passed unmodified.
//  - rvalid/rdata routed to the requester recorded at grant; other side's rvalid stays 0.
//  - rdata holds last value between pulses.
//  - Reset mid-transaction: abort immediately, no rvalid/gnt after release.
// TESTING
//  1 if_req, if_addr=0x010, mem_rdata=0xDEADBEEF -> if_gnt+mem_read cyc1 (addr 0x010,
//    size 10), if_rvalid cyc3, if_rdata=0xDEADBEEF.
//  2 if_req and d_req held high from reset -> grants d,if,d,if...; never two in one cycle.
//  3 load addr 0x003, mem_rdata=0x80FF1234: LB -> 0xFFFFFF80, LBU -> 0x00000080;
//    LH addr 0x002 -> 0xFFFF80FF.
//  4 SB addr 0x001 d_wdata=0x000000AB -> mem_write 1 cycle, mem_wdata=0x0000AB00,
//    mem_size=00, no d_rvalid.
//  5 LW addr 0x006 -> d_gnt and d_misaligned pulse together, no mem_read, no d_rvalid.
//  6 RD_LAT=3, rst_n low during WAIT -> outputs 0 at once, no rvalid after release;
//    next fetch completes normally.

Source files
------------

// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - fetch, load/store and memory-controller signal bundle for mem_access_arbiter
// Signals:
//   if_*   instruction-fetch requester (word reads only)
//   d_*    load/store requester
//   mem_*  memory_controller / BRAM side
// Modports:
//   slave  arbiter view (requests and mem_rdata in; grants, read data and mem strobes out)
//   master requester/memory view (the opposite directions)
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_unsigned;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_misaligned;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output d_gnt, d_misaligned, d_rvalid, d_rdata,
        output mem_read, mem_write, mem_size, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  d_gnt, d_misaligned, d_rvalid, d_rdata,
        input  mem_read, mem_write, mem_size, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin sharing of the data-memory port between fetch and load/store
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_access_arbiter_if.slave: both requesters plus the memory_controller side
// Parameters:
//   ADDR_W byte-address width, RD_LAT BRAM read latency after mem_read (1..4)
module mem_access_arbiter #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state;
    logic        last_d;   // 1: data side won the most recent grant
    logic        own_d;    // owner of the transaction in flight
    logic        rd_q;     // transaction in flight needs a read return
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  cnt;

    logic              any_req;
    logic              pick_d;
    logic              d_mis;
    logic [1:0]        d_size_n;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       rd_shift;
    logic [31:0]       ext;

    assign any_req  = bus.if_req | bus.d_req;
    // On a tie the side that did not win last time gets the port.
    assign pick_d   = bus.d_req & (~bus.if_req | ~last_d);
    assign d_size_n = (bus.d_size == 2'b11) ? 2'b10 : bus.d_size;
    assign d_mis    = ((d_size_n == 2'b01) && bus.d_addr[0]) ||
                      ((d_size_n == 2'b10) && (bus.d_addr[1:0] != 2'b00));
    assign sel_addr = pick_d ? bus.d_addr : bus.if_addr;

    // Fetches are recorded as lane 0 / word so the raw word passes through unchanged.
    assign rd_shift = bus.mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        ext = rd_shift;
        case (size_q)
            2'b00:   ext = {{24{rd_shift[7] & ~uns_q}}, rd_shift[7:0]};
            2'b01:   ext = {{16{rd_shift[15] & ~uns_q}}, rd_shift[15:0]};
            default: ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            last_d           <= 1'b0;
            own_d            <= 1'b0;
            rd_q             <= 1'b0;
            lane_q           <= 2'b00;
            size_q           <= 2'b00;
            uns_q            <= 1'b0;
            cnt              <= 2'd0;
            bus.if_gnt       <= 1'b0;
            bus.if_rvalid    <= 1'b0;
            bus.if_rdata     <= 32'd0;
            bus.d_gnt        <= 1'b0;
            bus.d_misaligned <= 1'b0;
            bus.d_rvalid     <= 1'b0;
            bus.d_rdata      <= 32'd0;
            bus.mem_read     <= 1'b0;
            bus.mem_write    <= 1'b0;
            bus.mem_size     <= 2'b00;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= 32'd0;
        end else begin
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state        <= ISSUE;
                        last_d       <= pick_d;
                        own_d        <= pick_d;
                        bus.mem_addr <= sel_addr;
                        if (pick_d) begin
                            bus.d_gnt        <= 1'b1;
                            bus.d_misaligned <= d_mis;
                            bus.mem_read     <= ~bus.d_we & ~d_mis;
                            bus.mem_write    <= bus.d_we & ~d_mis;
                            bus.mem_size     <= d_size_n;
                            bus.mem_wdata    <= bus.d_wdata << {bus.d_addr[1:0], 3'b000};
                            rd_q             <= ~bus.d_we & ~d_mis;
                            lane_q           <= bus.d_addr[1:0];
                            size_q           <= d_size_n;
                            uns_q            <= bus.d_unsigned;
                        end else begin
                            bus.if_gnt    <= 1'b1;
                            bus.mem_read  <= 1'b1;
                            bus.mem_write <= 1'b0;
                            bus.mem_size  <= 2'b10;
                            bus.mem_wdata <= 32'd0;
                            rd_q          <= 1'b1;
                            lane_q        <= 2'b00;
                            size_q        <= 2'b10;
                            uns_q         <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    bus.if_gnt       <= 1'b0;
                    bus.d_gnt        <= 1'b0;
                    bus.d_misaligned <= 1'b0;
                    bus.mem_read     <= 1'b0;
                    bus.mem_write    <= 1'b0;
                    cnt              <= 2'(RD_LAT - 1);
                    state            <= rd_q ? WAIT : IDLE;
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= IDLE;
                        if (own_d) begin
                            bus.d_rvalid <= 1'b1;
                            bus.d_rdata  <= ext;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= ext;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - self-checking bench for mem_access_arbiter (RD_LAT 1 and 3 instances)
module tb_mem_access_arbiter;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_access_arbiter_if #(.ADDR_W(AW)) b1 ();
    mem_access_arbiter_if #(.ADDR_W(AW)) b3 ();

    mem_access_arbiter #(.ADDR_W(AW), .RD_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mem_access_arbiter #(.ADDR_W(AW), .RD_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [3:0]  rp1 = '0;
    logic [3:0]  rp3 = '0;
    logic [7:0]  ra1 [4];
    logic [7:0]  ra3 [4];

    logic [31:0] q1f [$];
    logic [31:0] q1d [$];
    logic [31:0] q3f [$];
    logic [31:0] e_mon;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] a);
        logic [3:0]  be;
        logic [31:0] r;
        be = (sz == 2'b00) ? (4'b0001 << a) : (sz == 2'b01) ? (4'b0011 << a) : 4'b1111;
        r  = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // BRAM models: data presented exactly RD_LAT cycles after mem_read, garbage otherwise.
    always @(posedge clk) begin
        if (b1.mem_write)
            mem1[b1.mem_addr[9:2]] = merge(mem1[b1.mem_addr[9:2]], b1.mem_wdata, b1.mem_size, b1.mem_addr[1:0]);
        rp1    <= {rp1[2:0], b1.mem_read};
        rp3    <= {rp3[2:0], b3.mem_read};
        ra1[0] <= b1.mem_addr[9:2];
        ra3[0] <= b3.mem_addr[9:2];
        for (int i = 1; i < 4; i++) begin
            ra1[i] <= ra1[i-1];
            ra3[i] <= ra3[i-1];
        end
    end

    assign b1.mem_rdata = rp1[0] ? mem1[ra1[0]] : 32'hBAD0_BAD0;
    assign b3.mem_rdata = rp3[2] ? mem3[ra3[2]] : 32'hBAD0_BAD0;

    // Scoreboard: every rvalid pops the expectation pushed when its request was driven.
    always @(negedge clk) begin
        if (b1.if_rvalid) begin
            n_chk++;
            if (q1f.size() == 0) begin
                n_fail++; $display("FAIL u1_if_rvalid_unexpected got=%h", b1.if_rdata);
            end else begin
                e_mon = q1f.pop_front();
                if (b1.if_rdata !== e_mon) begin
                    n_fail++; $display("FAIL u1_if_rdata got=%h exp=%h", b1.if_rdata, e_mon);
                end
            end
        end
        if (b1.d_rvalid) begin
            n_chk++;
            if (q1d.size() == 0) begin
                n_fail++; $display("FAIL u1_d_rvalid_unexpected got=%h", b1.d_rdata);
            end else begin
                e_mon = q1d.pop_front();
                if (b1.d_rdata !== e_mon) begin
                    n_fail++; $display("FAIL u1_d_rdata got=%h exp=%h", b1.d_rdata, e_mon);
                end
            end
        end
        if (b3.if_rvalid) begin
            n_chk++;
            if (q3f.size() == 0) begin
                n_fail++; $display("FAIL u3_if_rvalid_unexpected got=%h", b3.if_rdata);
            end else begin
                e_mon = q3f.pop_front();
                if (b3.if_rdata !== e_mon) begin
                    n_fail++; $display("FAIL u3_if_rdata got=%h exp=%h", b3.if_rdata, e_mon);
                end
            end
        end
        if (b3.d_rvalid) begin
            n_chk++; n_fail++;
            $display("FAIL u3_d_rvalid_unexpected got=1 exp=0");
        end
        if (b1.if_gnt || b1.d_gnt) begin
            n_chk++;
            if (b1.if_gnt && b1.d_gnt) begin
                n_fail++; $display("FAIL u1_dual_grant got=11 exp=one_hot");
            end
        end
    end

    function automatic logic sel_rv(input int w);
        case (w)
            0:       return b1.if_rvalid;
            1:       return b1.d_rvalid;
            default: return b3.if_rvalid;
        endcase
    endfunction

    task automatic wait_rv(input int w, output int n);
        n = 0;
        while (!sel_rv(w) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sel_rv(w)) n = -1;
    endtask

    task automatic issue_d(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [AW-1:0] a, input logic [31:0] wd, output int cyc);
        b1.d_req = 1'b1; b1.d_we = we; b1.d_size = sz; b1.d_unsigned = uns;
        b1.d_addr = a; b1.d_wdata = wd;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (b1.d_gnt) begin cyc = i; break; end
        end
        b1.d_req = 1'b0;
    endtask

    task automatic issue_f(input int u, input logic [AW-1:0] a, output int cyc);
        if (u == 1) begin b1.if_req = 1'b1; b1.if_addr = a; end
        else        begin b3.if_req = 1'b1; b3.if_addr = a; end
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((u == 1 && b1.if_gnt) || (u != 1 && b3.if_gnt)) begin cyc = i; break; end
        end
        if (u == 1) b1.if_req = 1'b0;
        else        b3.if_req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({b1.if_gnt, b1.if_rvalid, b1.d_gnt, b1.d_misaligned, b1.d_rvalid,
             b1.mem_read, b1.mem_write, b1.mem_size} !== 9'd0) begin
            n_fail++; $display("FAIL reset_u1_ctrl got=nonzero exp=0");
        end
        n_chk++;
        if ({b1.if_rdata, b1.d_rdata, b1.mem_wdata} !== 96'd0 || b1.mem_addr !== 10'd0) begin
            n_fail++; $display("FAIL reset_u1_data got=%h/%h/%h/%h exp=0", b1.if_rdata, b1.d_rdata, b1.mem_wdata, b1.mem_addr);
        end
        n_chk++;
        if ({b3.if_gnt, b3.if_rvalid, b3.mem_read, b3.mem_size, b3.mem_addr, b3.if_rdata} !== 46'd0) begin
            n_fail++; $display("FAIL reset_u3 got=nonzero exp=0");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch;
        int c, n;
        mem1[4] = 32'hDEADBEEF;
        q1f.push_back(32'hDEADBEEF);
        issue_f(1, 10'h010, c);
        n_chk++;
        if (c !== 1) begin n_fail++; $display("FAIL fetch_gnt_cycle got=%0d exp=1", c); end
        n_chk++;
        if ({b1.mem_read, b1.mem_write, b1.mem_size, b1.mem_addr, b1.d_gnt} !== {1'b1, 1'b0, 2'b10, 10'h010, 1'b0}) begin
            n_fail++; $display("FAIL fetch_issue got=rd%b wr%b sz%b a%h dg%b exp=rd1 wr0 sz10 a010 dg0",
                               b1.mem_read, b1.mem_write, b1.mem_size, b1.mem_addr, b1.d_gnt);
        end
        @(negedge clk);
        n_chk++;
        if (b1.mem_read !== 1'b0 || b1.if_gnt !== 1'b0) begin
            n_fail++; $display("FAIL fetch_pulse_width got=rd%b gnt%b exp=0", b1.mem_read, b1.if_gnt);
        end
        wait_rv(0, n);
        n_chk++;
        if (n !== 1) begin n_fail++; $display("FAIL fetch_rvalid_cycle got=%0d exp=1", n); end
        n_chk++;
        if (b1.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_route got=d_rvalid1 exp=0"); end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [7:0] seq;
        int         ngr;
        int         first;
        mem1[8]  = 32'h11112222;
        mem1[12] = 32'h33334444;
        rst_n = 1'b0;
        b1.if_req = 1'b1; b1.if_addr = 10'h020;
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_size = 2'b10; b1.d_unsigned = 1'b0;
        b1.d_addr = 10'h030; b1.d_wdata = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        seq = '0; ngr = 0; first = -1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (b1.d_gnt)  begin q1d.push_back(32'h33334444); seq = {seq[6:0], 1'b1}; ngr++; end
            if (b1.if_gnt) begin q1f.push_back(32'h11112222); seq = {seq[6:0], 1'b0}; ngr++; end
            if ((b1.d_gnt || b1.if_gnt) && first < 0) first = i;
            if (i == 24) begin b1.if_req = 1'b0; b1.d_req = 1'b0; end
        end
        n_chk++;
        if (first !== 1) begin n_fail++; $display("FAIL rr_first_cycle got=%0d exp=1", first); end
        n_chk++;
        if (ngr !== 8) begin n_fail++; $display("FAIL rr_grant_count got=%0d exp=8", ngr); end
        n_chk++;
        if (seq !== 8'b10101010) begin n_fail++; $display("FAIL rr_order got=%b exp=10101010", seq); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_load_ext;
        logic [1:0]  sz  [10];
        logic        un  [10];
        logic [9:0]  ad  [10];
        logic [31:0] ex  [10];
        int c, n;
        sz = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
        un = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ad = '{10'h003, 10'h003, 10'h002, 10'h002, 10'h000, 10'h001, 10'h000, 10'h000, 10'h002, 10'h000};
        ex = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000034,
               32'h00000012, 32'h00001234, 32'h80FF1234, 32'hFFFFFFFF, 32'h80FF1234};
        mem1[0] = 32'h80FF1234;
        for (int k = 0; k < 10; k++) begin
            q1d.push_back(ex[k]);
            issue_d(1'b0, sz[k], un[k], ad[k], 32'd0, c);
            n_chk++;
            if (c !== 1 || b1.mem_read !== 1'b1 || b1.d_misaligned !== 1'b0) begin
                n_fail++; $display("FAIL load%0d_issue got=c%0d rd%b mis%b exp=c1 rd1 mis0", k, c, b1.mem_read, b1.d_misaligned);
            end
            wait_rv(1, n);
            n_chk++;
            if (n !== 2) begin n_fail++; $display("FAIL load%0d_latency got=%0d exp=2", k, n); end
            @(negedge clk);
            n_chk++;
            if (b1.d_rdata !== ex[k] || b1.d_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL load%0d_hold got=%h v%b exp=%h v0", k, b1.d_rdata, b1.d_rvalid, ex[k]);
            end
        end
    endtask

    task automatic test_store;
        int c;
        issue_d(1'b1, 2'b00, 1'b0, 10'h001, 32'h000000AB, c);
        n_chk++;
        if (c !== 1 || {b1.mem_write, b1.mem_read, b1.mem_size, b1.mem_addr, b1.mem_wdata, b1.d_misaligned}
                       !== {1'b1, 1'b0, 2'b00, 10'h001, 32'h0000AB00, 1'b0}) begin
            n_fail++; $display("FAIL sb_issue got=c%0d wr%b rd%b sz%b a%h wd%h exp=c1 wr1 rd0 sz00 a001 wd0000ab00",
                               c, b1.mem_write, b1.mem_read, b1.mem_size, b1.mem_addr, b1.mem_wdata);
        end
        @(negedge clk);
        n_chk++;
        if (b1.mem_write !== 1'b0) begin n_fail++; $display("FAIL sb_pulse_width got=1 exp=0"); end
        issue_d(1'b1, 2'b01, 1'b0, 10'h006, 32'h0000BEEF, c);
        n_chk++;
        if ({b1.mem_write, b1.mem_size, b1.mem_wdata} !== {1'b1, 2'b01, 32'hBEEF0000}) begin
            n_fail++; $display("FAIL sh_issue got=wr%b sz%b wd%h exp=wr1 sz01 wdbeef0000", b1.mem_write, b1.mem_size, b1.mem_wdata);
        end
        issue_d(1'b1, 2'b11, 1'b0, 10'h008, 32'h12345678, c);
        n_chk++;
        if ({b1.mem_write, b1.mem_size, b1.mem_wdata} !== {1'b1, 2'b10, 32'h12345678}) begin
            n_fail++; $display("FAIL sw11_issue got=wr%b sz%b wd%h exp=wr1 sz10 wd12345678", b1.mem_write, b1.mem_size, b1.mem_wdata);
        end
        repeat (4) @(negedge clk);
        q1d.push_back(32'h80FFAB34);
        issue_d(1'b0, 2'b10, 1'b0, 10'h000, 32'd0, c);
        repeat (3) @(negedge clk);
        q1d.push_back(32'hBEEF0000);
        issue_d(1'b0, 2'b10, 1'b0, 10'h004, 32'd0, c);
        repeat (3) @(negedge clk);
        q1d.push_back(32'h12345678);
        issue_d(1'b0, 2'b10, 1'b0, 10'h008, 32'd0, c);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int c, n;
        issue_d(1'b1, 2'b00, 1'b0, 10'h00C, 32'h0000005A, c);
        q1f.push_back(32'h11112222);
        issue_f(1, 10'h020, c);
        n_chk++;
        if (c !== 2) begin n_fail++; $display("FAIL b2b_store_fetch got=%0d exp=2", c); end
        wait_rv(0, n);
        n_chk++;
        if (n !== 2) begin n_fail++; $display("FAIL b2b_fetch_latency got=%0d exp=2", n); end
        q1d.push_back(32'h0000005A);
        issue_d(1'b0, 2'b10, 1'b0, 10'h00C, 32'd0, c);
        q1f.push_back(32'h11112222);
        issue_f(1, 10'h020, c);
        n_chk++;
        if (c !== 3) begin n_fail++; $display("FAIL b2b_load_fetch got=%0d exp=3", c); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_misaligned;
        int c;
        issue_d(1'b0, 2'b10, 1'b0, 10'h006, 32'd0, c);
        n_chk++;
        if (c !== 1 || {b1.d_misaligned, b1.mem_read, b1.mem_write} !== 3'b100) begin
            n_fail++; $display("FAIL lw_misaligned got=c%0d mis%b rd%b wr%b exp=c1 mis1 rd0 wr0",
                               c, b1.d_misaligned, b1.mem_read, b1.mem_write);
        end
        @(negedge clk);
        n_chk++;
        if (b1.d_misaligned !== 1'b0) begin n_fail++; $display("FAIL misaligned_pulse got=1 exp=0"); end
        issue_d(1'b1, 2'b01, 1'b0, 10'h001, 32'h0000FFFF, c);
        n_chk++;
        if ({b1.d_misaligned, b1.mem_read, b1.mem_write} !== 3'b100) begin
            n_fail++; $display("FAIL sh_misaligned got=mis%b rd%b wr%b exp=mis1 rd0 wr0", b1.d_misaligned, b1.mem_read, b1.mem_write);
        end
        issue_d(1'b0, 2'b01, 1'b1, 10'h003, 32'd0, c);
        n_chk++;
        if ({b1.d_misaligned, b1.mem_read} !== 2'b10) begin
            n_fail++; $display("FAIL lh_misaligned got=mis%b rd%b exp=mis1 rd0", b1.d_misaligned, b1.mem_read);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int c, n;
        mem3[4] = 32'hCAFEF00D;
        q3f.push_back(32'hCAFEF00D);
        issue_f(3, 10'h010, c);
        wait_rv(2, n);
        n_chk++;
        if (c !== 1 || n !== 4) begin n_fail++; $display("FAIL lat3_fetch got=c%0d n%0d exp=c1 n4", c, n); end
        @(negedge clk);
        q3f.push_back(32'hCAFEF00D);
        issue_f(3, 10'h010, c);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q3f.delete();
        n_chk++;
        if ({b3.if_rdata, b3.mem_addr, b3.mem_size, b3.if_gnt, b3.mem_read} !== 46'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs got=rd%h a%h sz%b exp=0", b3.if_rdata, b3.mem_addr, b3.mem_size);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        q3f.push_back(32'hCAFEF00D);
        issue_f(3, 10'h010, c);
        wait_rv(2, n);
        n_chk++;
        if (c !== 1 || n !== 4) begin n_fail++; $display("FAIL after_reset_fetch got=c%0d n%0d exp=c1 n4", c, n); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_size = 2'b00;
        b1.d_unsigned = 1'b0; b1.d_addr = '0; b1.d_wdata = 32'd0;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_size = 2'b00;
        b3.d_unsigned = 1'b0; b3.d_addr = '0; b3.d_wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 32'd0;
            mem3[i] = 32'd0;
        end
        test_reset;
        test_fetch;
        test_round_robin;
        test_load_ext;
        test_store;
        test_back_to_back;
        test_misaligned;
        test_reset_mid;
        n_chk++;
        if (q1f.size() + q1d.size() + q3f.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain got=%0d/%0d/%0d exp=0/0/0", q1f.size(), q1d.size(), q3f.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
